// File: rtl/uoram_block_adapter_pkg.sv
// rtl/uoram_block_adapter_pkg.sv - shared command encodings, beat math and FSM states for the block adapter
package uoram_block_adapter_pkg;

    // Backend command encodings shared with the ORAM controller
    localparam logic [1:0] BECMD_Read    = 2'd0;
    localparam logic [1:0] BECMD_Write   = 2'd1;
    localparam logic [1:0] BECMD_Append  = 2'd2;
    localparam logic [1:0] BECMD_ReadRmv = 2'd3;

    // Adapter request lifecycle: accept, issue to controller, collect beats, hand back
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StRecv  = 2'd2,
        StResp  = 2'd3
    } adapterState_t;

    // Number of beats needed to cover a block, rounding up
    function automatic int divceil(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    // Write and Append carry block data toward the controller; Read and ReadRmv expect data back
    function automatic logic isWriteCmd(input logic [1:0] cmd);
        return (cmd == BECMD_Write) || (cmd == BECMD_Append);
    endfunction

endpackage

// File: rtl/uoram_beat_shifter.sv
// rtl/uoram_beat_shifter.sv - block<->beat serializer/deserializer with beat counter
module uoram_beat_shifter
    import uoram_block_adapter_pkg::*;
#(
    parameter int Width        = 512,
    parameter int BeatWidth    = 64,
    parameter bit CaptureBeats = 1'b0
) (
    input  logic                 Clock,
    input  logic                 Reset_n,
    input  logic                 Clear,
    input  logic                 Load,
    input  logic [Width-1:0]     LoadData,
    input  logic                 Advance,
    input  logic [BeatWidth-1:0] BeatIn,
    output logic [Width-1:0]     Block,
    output logic [BeatWidth-1:0] BeatOut,
    output logic                 Last
);

    localparam int NumChunks  = divceil(Width, BeatWidth);
    localparam int PadWidth   = NumChunks * BeatWidth;
    localparam int CountWidth = $clog2(NumChunks) + 1;
    localparam logic [CountWidth-1:0] LastCount = CountWidth'(NumChunks - 1);

    // The block is held zero-padded to a whole number of beats so the last
    // beat drives zeros above the block width and returned pad bits are dropped.
    logic [PadWidth-1:0]   blockReg;
    logic [CountWidth-1:0] count;

    // Load a block or capture one beat per handshake; the counter tracks the beat index
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            blockReg <= '0;
            count    <= '0;
        end else if (Load || Clear) begin
            count <= '0;
            if (Load) begin
                blockReg <= PadWidth'(LoadData);
            end
        end else if (Advance) begin
            count <= count + 1'b1;
            if (CaptureBeats) begin
                blockReg[int'(count) * BeatWidth +: BeatWidth] <= BeatIn;
            end
        end
    end

    assign BeatOut = blockReg[int'(count) * BeatWidth +: BeatWidth];
    assign Block   = blockReg[Width-1:0];
    assign Last    = (count == LastCount);

endmodule

// File: rtl/uoram_block_adapter.sv
// rtl/uoram_block_adapter.sv - whole-block client adapter in front of the ORAM controller (optional UORAM_ADAPTER_STATS_EN adds Stats port)
module uoram_block_adapter
    import uoram_block_adapter_pkg::*;
#(
    parameter int ORAMU      = 32,
    parameter int ORAMB      = 512,
    parameter int FEDWidth   = 64,
    parameter int DMWidth    = 8,
    parameter int BECMDWidth = 2
) (
    input  logic                  Clock,
    input  logic                  Reset_n,
    input  logic                  ReqValid,
    output logic                  ReqReady,
    input  logic [BECMDWidth-1:0] ReqCmd,
    input  logic [ORAMU-1:0]      ReqAddr,
    input  logic [DMWidth-1:0]    ReqMask,
    input  logic [ORAMB-1:0]      ReqData,
    output logic                  RespValid,
    input  logic                  RespReady,
    output logic [ORAMB-1:0]      RespData,
    output logic [ORAMU-1:0]      RespAddr,
    output logic                  CmdOutValid,
    input  logic                  CmdOutReady,
    output logic [BECMDWidth-1:0] CmdOut,
    output logic [ORAMU-1:0]      ProgAddrOut,
    output logic [DMWidth-1:0]    WMaskOut,
    output logic                  DataOutValid,
    input  logic                  DataOutReady,
    output logic [FEDWidth-1:0]   DataOut,
    input  logic                  ReturnDataValid,
    output logic                  ReturnDataReady,
    input  logic [FEDWidth-1:0]   ReturnData
`ifdef UORAM_ADAPTER_STATS_EN
    ,
    output logic [63:0]           Stats
`endif
);

    adapterState_t state;

    logic accept;
    logic sendFire;
    logic recvFire;
    logic sendLast;
    logic recvLast;
    logic cmdDone;
    logic dataDone;

    logic [ORAMB-1:0]    unusedSendBlock;
    logic [FEDWidth-1:0] unusedRecvBeat;

    assign accept   = (state == StIdle) && ReqValid && ReqReady;
    assign sendFire = DataOutValid && DataOutReady;
    assign recvFire = ReturnDataValid && ReturnDataReady;

    // The command and data channels finish independently, possibly in the same cycle
    assign cmdDone  = !CmdOutValid || CmdOutReady;
    assign dataDone = !DataOutValid || (DataOutReady && sendLast);

    // Write path: block captured at accept, one beat per DataOut handshake
    uoram_beat_shifter #(
        .Width        (ORAMB),
        .BeatWidth    (FEDWidth),
        .CaptureBeats (1'b0)
    ) sendShifter (
        .Clock    (Clock),
        .Reset_n  (Reset_n),
        .Clear    (accept),
        .Load     (accept),
        .LoadData (ReqData),
        .Advance  (sendFire),
        .BeatIn   ({FEDWidth{1'b0}}),
        .Block    (unusedSendBlock),
        .BeatOut  (DataOut),
        .Last     (sendLast)
    );

    // Read path: returned beats assembled in place into the response block
    uoram_beat_shifter #(
        .Width        (ORAMB),
        .BeatWidth    (FEDWidth),
        .CaptureBeats (1'b1)
    ) recvShifter (
        .Clock    (Clock),
        .Reset_n  (Reset_n),
        .Clear    (accept),
        .Load     (1'b0),
        .LoadData ({ORAMB{1'b0}}),
        .Advance  (recvFire),
        .BeatIn   (ReturnData),
        .Block    (RespData),
        .BeatOut  (unusedRecvBeat),
        .Last     (recvLast)
    );

    assign RespAddr = ProgAddrOut;

    // Request FSM with registered handshake outputs; one request in flight at a time
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state           <= StIdle;
            ReqReady        <= 1'b0;
            CmdOutValid     <= 1'b0;
            DataOutValid    <= 1'b0;
            ReturnDataReady <= 1'b0;
            RespValid       <= 1'b0;
            CmdOut          <= '0;
            ProgAddrOut     <= '0;
            WMaskOut        <= '0;
        end else begin
            case (state)
                StIdle: begin
                    if (accept) begin
                        ReqReady     <= 1'b0;
                        CmdOut       <= ReqCmd;
                        ProgAddrOut  <= ReqAddr;
                        // Append always writes the whole block
                        WMaskOut     <= (ReqCmd == BECMD_Append) ? {DMWidth{1'b1}} : ReqMask;
                        CmdOutValid  <= 1'b1;
                        DataOutValid <= isWriteCmd(ReqCmd);
                        state        <= StIssue;
                    end else begin
                        ReqReady <= 1'b1;
                    end
                end
                StIssue: begin
                    if (CmdOutValid && CmdOutReady) begin
                        CmdOutValid <= 1'b0;
                    end
                    if (sendFire && sendLast) begin
                        DataOutValid <= 1'b0;
                    end
                    if (cmdDone && dataDone) begin
                        if (isWriteCmd(CmdOut)) begin
                            ReqReady <= 1'b1;
                            state    <= StIdle;
                        end else begin
                            ReturnDataReady <= 1'b1;
                            state           <= StRecv;
                        end
                    end
                end
                StRecv: begin
                    if (recvFire && recvLast) begin
                        ReturnDataReady <= 1'b0;
                        RespValid       <= 1'b1;
                        state           <= StResp;
                    end
                end
                StResp: begin
                    if (RespReady) begin
                        RespValid <= 1'b0;
                        ReqReady  <= 1'b1;
                        state     <= StIdle;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

`ifdef UORAM_ADAPTER_STATS_EN
    logic [31:0] reqCount;
    logic [31:0] busyCycles;

    // Saturating activity counters: accepted requests and cycles spent outside IDLE
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            reqCount   <= '0;
            busyCycles <= '0;
        end else begin
            if (accept && (reqCount != 32'hFFFF_FFFF)) begin
                reqCount <= reqCount + 32'd1;
            end
            if ((state != StIdle) && (busyCycles != 32'hFFFF_FFFF)) begin
                busyCycles <= busyCycles + 32'd1;
            end
        end
    end

    assign Stats = {busyCycles, reqCount};
`endif

endmodule

// File: doc/uoram_block_adapter.md
Name: uoram_block_adapter

Overview:
Client-side stage directly upstream of the unified ORAM controller. Accepts one whole-block request (cmd, addr, mask, ORAMB-bit data) from the client. Issues the command and serializes write data into FEDWidth beats toward the controller. For read-type commands, collects the returned beats and presents one whole-block response; exactly one request is in flight at a time.

Parameters:
ORAMU, 32, program address width
ORAMB, 512, block width in bits
FEDWidth, 64, beat width toward the controller
DMWidth, 8, write-mask width (one bit per beat)
BECMDWidth, 2, command width; encodings Read=0, Write=1, Append=2, ReadRmv=3 (from shared package)

Ports:
Clock  in  1  single clock
Reset_n  in  1  asynchronous active-low reset
ReqValid  in  1  client request valid
ReqReady  out  1  adapter can accept a request
ReqCmd  in  BECMDWidth  client command
ReqAddr  in  ORAMU  client block address
ReqMask  in  DMWidth  client write mask
ReqData  in  ORAMB  client block data (Write/Append only)
RespValid  out  1  response block valid
RespReady  in  1  client accepts response
RespData  out  ORAMB  returned block
RespAddr  out  ORAMU  address of the returned block
CmdOutValid  out  1  command valid toward controller
CmdOutReady  in  1  controller accepts command
CmdOut  out  BECMDWidth  latched command
ProgAddrOut  out  ORAMU  latched address
WMaskOut  out  DMWidth  latched mask; forced all-ones for Append
DataOutValid  out  1  write beat valid
DataOutReady  in  1  controller accepts beat
DataOut  out  FEDWidth  write beat
ReturnDataValid  in  1  read beat valid from controller
ReturnDataReady  out  1  adapter accepts read beat
ReturnData  in  FEDWidth  read beat

Behaviour:
- Constants:
  - NumChunks = ceil(ORAMB/FEDWidth).
  - Beat k carries bits [k*FEDWidth +: FEDWidth]; beat 0 is sent first.
  - Bits above ORAMB in the last beat are zero on output and discarded on input.
- Reset (async, Reset_n=0):
  - FSM goes to IDLE; beat counters are 0.
  - ReqReady=0 while in reset, then 1 in IDLE.
  - RespValid, CmdOutValid, DataOutValid and ReturnDataReady are 0; RespData=0.
  - A request in flight when reset asserts is dropped silently.
- FSM states:
  - IDLE: ReqReady=1. On ReqValid&&ReqReady, latch cmd/addr/mask/data, set CmdPending=1, set DataPending=(cmd is Write or Append), clear counters, go to ISSUE.
  - ISSUE:
    - CmdOutValid=CmdPending, cleared on CmdOutReady.
    - DataOutValid=DataPending. Each DataOutReady handshake advances the send counter; DataPending clears after beat NumChunks-1.
    - Command and data channels are independent; either order is legal.
    - When both are cleared (same-cycle completion allowed): Read/ReadRmv go to RECV; Write/Append go to IDLE.
  - RECV:
    - ReturnDataReady=1; each handshake writes beat k into the response register and increments k.
    - On beat NumChunks-1, go to RESP the next cycle.
  - RESP: RespValid=1 with RespData/RespAddr stable until RespReady, then go to IDLE.
- Handshake rules:
  - ReturnDataReady=0 outside RECV; beats arriving early stall at the controller, never dropped.
  - All outputs are held stable while valid and not ready.
- Throughput:
  - Minimum latency IDLE→ISSUE is 1 cycle.
  - A Write with back-to-back ready completes in max(1, NumChunks) cycles in ISSUE.
  - A new request may be accepted the cycle after returning to IDLE; there is no bypass of IDLE.
- Counter widths: clog2(NumChunks)+1 bits; no wrap (terminal compare is NumChunks-1).

Optional Feature:
UORAM_ADAPTER_STATS_EN:
- Enabled: adds 32-bit saturating counters ReqCount (incremented per accepted request) and BusyCycles (incremented every cycle not in IDLE), both cleared by reset. They are exposed on extra output port Stats[63:0] = {BusyCycles, ReqCount}.
- Disabled: the port and logic are absent; core behaviour is identical.

Decomposition:
- Shared package: the BECMD_* encodings, the NumChunks divceil function and the FSM state typedef.
- Sub-module uoram_beat_shifter: a parameterized ORAMB↔FEDWidth serializer/deserializer with counter. It is instantiated twice (send and receive paths).

Test Plan:
- Write addr=5, data=512'h0123…, mask=8'hFF, all readies high: CmdOut=1 and 8 beats sent, beat0=data[63:0]; back in IDLE after 8 ISSUE cycles; no RespValid.
- Read addr=5 with controller returning 8 beats 64'h1..64'h8: RespData[63:0]=1, [511:448]=8, RespAddr=5; RespValid held while RespReady=0 for 3 cycles.
- Write with CmdOutReady held low 10 cycles while DataOutReady=1: all 8 beats sent first, ISSUE exits only after the command handshake.
- Append with ReqMask=8'h0F: WMaskOut=8'hFF.
- ReturnDataValid asserted during ISSUE of a Read: ReturnDataReady=0 until RECV, and no beat is lost.
- Reset_n pulsed low mid-RECV after 3 beats: all valids drop immediately, ReqReady=1 after release, and the next Read completes correctly.
